// File: rtl/bit_stream_serializer_if.sv
// rtl/bit_stream_serializer_if.sv - producer/consumer handshake bundle for the bit stream serializer
interface bit_stream_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din_data;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_enable;
    logic             word_done;
    logic             busy;

    // Serializer side
    modport slave (
        input  din_data,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        input  sout_enable,
        output word_done,
        output busy
    );

    // Producer/consumer side
    modport master (
        output din_data,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        output sout_enable,
        input  word_done,
        input  busy
    );
endinterface

// File: rtl/bit_stream_serializer.sv
// rtl/bit_stream_serializer.sv - parallel word to serial bit stream with one-word holding register
module bit_stream_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    bit_stream_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q;
    logic             word_done_q;

    logic [WIDTH-1:0] shreg_shift_d;
    logic             accept;
    logic             last_consumed;

    // Handshake decode; ready depends only on the registered hold flag
    assign accept        = bus.din_valid && !hold_full_q && !reset;
    assign last_consumed = (state_q == ST_SHIFT) && bus.sout_enable && (cnt_q == CNT_LAST);

    // Shifter contents after presenting the next bit at the output end
    always_comb begin
        shreg_shift_d = shreg_q;
        if (MSB_FIRST) begin
            shreg_shift_d = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shreg_shift_d = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Serializer FSM: load, shift, refill from hold or input on the last bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shreg_q <= bus.din_data;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (last_consumed) begin
                        word_done_q <= 1'b1;
                        cnt_q       <= '0;
                        if (hold_full_q) begin
                            // accept is necessarily low here, so hold cannot be overwritten
                            shreg_q     <= hold_q;
                            hold_full_q <= 1'b0;
                        end else if (accept) begin
                            shreg_q <= bus.din_data;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        if (bus.sout_enable) begin
                            shreg_q <= shreg_shift_d;
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                        if (accept) begin
                            hold_q      <= bus.din_data;
                            hold_full_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.din_ready  = !hold_full_q;
    assign bus.sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign bus.sout_valid = (state_q == ST_SHIFT);
    assign bus.word_done  = word_done_q;
    assign bus.busy       = (state_q == ST_SHIFT) || hold_full_q;
endmodule
